approx_prod_accumulator: RTL
============================

Name: approx_prod_accumulator

Overview:
- Downstream consumer of the 4x4 approximate multiplier array.
- Accepts the array's 8-bit products one per cycle over a valid/ready handshake.
- Accumulates each group of products into a saturating sum, i.e. an approximate dot product.
- Presents each finished sum with a sticky overflow flag on a valid/ready output, to the error-analysis/MAC stage.

Parameters:
- ACC_W, 16, accumulator and output sum width in bits; legal range 8..32.
- LEN, 8, products per group; legal range 1..256.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_prod is valid
- in_ready  output  1  block accepts in_prod this cycle
- in_prod  input  8  unsigned product from the multiplier array
- in_last  input  1  beat closes the current group early; sampled only on accept
- out_valid  output  1  out_sum/out_ovf valid
- out_ready  input  1  consumer accepts the result
- out_sum  output  ACC_W  saturated group sum
- out_ovf  output  1  saturation occurred at least once in this group
- out_cnt  output  9  number of products summed into out_sum (1..LEN)

Behaviour:
- Reset:
  - Sampled on clk edge when rst_n=0. Dominates all other inputs.
  - Result: state=ACCUM, acc=0, cnt=0, ovf=0.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_cnt=0.
  - A reset mid-group or mid-hold discards all partial and pending results.
- Accept condition: accept = in_valid & in_ready. Nothing changes on a cycle without accept.
- ACCUM state, in_ready=1:
  - On accept, the accumulator is updated by a saturating add: {ovf, acc} <= sat_add(acc, zero-extended in_prod).
  - If acc + in_prod > 2^ACC_W-1, acc saturates to 2^ACC_W-1 and ovf is set. ovf is sticky until the group is cleared.
  - On accept, cnt <= cnt+1.
  - If the accepted beat has cnt==LEN-1 or in_last=1, the group closes and the block moves to HOLD on the next edge.
  - On close, out_sum, out_ovf and out_cnt are loaded with the post-add values.
- HOLD state, in_ready=0, out_valid=1:
  - out_sum, out_ovf and out_cnt are held stable while out_ready=0.
  - When out_ready=1: next edge sets out_valid=0 and clears acc, cnt and ovf to 0, returning to ACCUM.
- Latency and throughput:
  - out_valid rises on the edge after the closing beat is accepted.
  - Exactly one bubble cycle per group: in_ready stays 0 during the hand-off edge.
  - Best-case throughput is LEN products per LEN+1 cycles.
- Boundary conditions:
  - LEN=1: every accepted beat closes a group; out_cnt=1.
  - in_last on the first beat: out_cnt=1.
  - in_last together with cnt==LEN-1: a single close, no double output.
  - in_valid while in HOLD is ignored (not accepted). The upstream must hold the beat, per standard valid/ready.
  - A product of 0 is still counted.
  - Maximum product 225 is accepted unmodified; the block applies no correction to approximate products.
  - cnt never wraps: the group always closes at LEN.
- Output registers: out_sum, out_ovf and out_cnt are registered. No combinational path from inputs to outputs, except in_ready, which is derived from the state register only.

Decomposition:
- Shared package approx_pkg holds:
  - state enum acc_state_t {ACCUM, HOLD};
  - constant PROD_W=8;
  - localparam CNT_W=9 for out_cnt.
- One natural sub-module: sat_add (ACC_W-bit unsigned add of a PROD_W operand, saturating, with an overflow-out flag). Purely combinational, instantiated once.
- The FSM and registers live in the top module.

Test Plan:
- Reset, then 8 beats of prod=10 with out_ready=1 → one out_valid pulse with out_sum=80, out_cnt=8, out_ovf=0. in_ready is low for exactly 1 cycle after the 8th accept.
- ACC_W=8, beats 200 then 100 then six 0s → out_sum=255, out_ovf=1, out_cnt=8. The next group of eight 1s gives out_sum=8, out_ovf=0, confirming ovf is cleared.
- Beats 5, 7, 9 with in_last on the third beat → out_sum=21, out_cnt=3. The following group starts from 0.
- Hold out_ready=0 for 5 cycles after close while in_valid=1 with prod=50 → out_sum is stable, in_ready=0, and no beat is accepted. Releasing out_ready lets the next group accept the 50 as its first beat.
- Assert rst_n=0 for one cycle after 4 beats of 30 → out_valid stays 0. A following 8-beat group of 1s yields out_sum=8.
- LEN=1 with random in_valid gaps → one output per accepted beat, with out_sum equal to that beat's in_prod and out_cnt=1.

Source files
------------

// File: rtl/approx_pkg.sv
// Shared types and constants for the approximate product accumulator.
package approx_pkg;

  // Width of one product from the 4x4 approximate multiplier array
  localparam int unsigned PROD_W = 8;

  // Width of the group beat counter and out_cnt (holds up to LEN=256)
  localparam int unsigned CNT_W = 9;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/approx_prod_accumulator_sat_add.sv
// Saturating unsigned add of a PROD_W-bit product onto an ACC_W-bit accumulator.
module sat_add
  import approx_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] full;

  // One guard bit catches the carry; on carry, clamp to all-ones
  always_comb begin
    full = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
    ovf  = full[ACC_W];
    sum  = full[ACC_W] ? '1 : full[ACC_W-1:0];
  end

endmodule

// File: rtl/approx_prod_accumulator.sv
// Accumulates groups of approximate products into saturating sums and
// hands each finished sum downstream over a valid/ready interface.
module approx_prod_accumulator
  import approx_pkg::*;
#(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned LEN   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic [8:0]        out_cnt
);

  acc_state_t        state_q, state_d;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  logic [ACC_W-1:0]  add_sum;
  logic              add_ovf;
  logic              accept;
  logic              close;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (in_prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Handshake and group-close decode; ready/valid come from state only
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    accept    = in_valid & in_ready;
    close     = accept & (in_last | (cnt == CNT_W'(LEN - 1)));
  end

  // Next-state: close a group into HOLD, release it on out_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (close) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Accumulator, counter, sticky overflow and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
      out_cnt <= '0;
    end else if (state_q == ACCUM) begin
      if (accept) begin
        acc <= add_sum;
        cnt <= cnt + CNT_W'(1);
        ovf <= ovf | add_ovf;
        if (close) begin
          out_sum <= add_sum;
          out_ovf <= ovf | add_ovf;
          out_cnt <= cnt + CNT_W'(1);
        end
      end
    end else if (out_ready) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

endmodule
